verdict_frame_tx: RTL and testbench

Output-side companion to the generated RTLola monitor (`topEntity`). It observes the monitor's two output streams and their `_aktv` flags, and timestamps every cycle in which at least one stream is active. It buffers those verdict events in a FIFO and serialises them as variable-length byte frames on a valid/ready stream toward the host link. The input sequencer drives the monitor; this block is the reader at the other end.

---
 rtl/verdict_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/verdict_frame_tx.sv | 114 +++++++++++
 tb/tb_verdict_frame_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verdict_pkg.sv
// Shared types for the verdict frame transmitter.
// Entry layout, FSM states and header helper.
package verdict_pkg;

    localparam int TS_W = 16;
    localparam int VAL_W = 8;
    localparam logic [3:0] HDR_MAGIC = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS_HI,
        ST_TS_LO,
        ST_VAL_B,
        ST_VAL_C
    } tx_state_t;

    typedef struct packed {
        logic [TS_W-1:0]         ts;
        logic                    b_aktv;
        logic                    c_aktv;
        logic signed [VAL_W-1:0] b;
        logic signed [VAL_W-1:0] c;
    } verdict_entry_t;

    localparam int ENTRY_W = $bits(verdict_entry_t);

    function automatic logic [7:0] hdr_byte(input verdict_entry_t e);
        return {HDR_MAGIC, 2'b00, e.c_aktv, e.b_aktv};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
        else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/verdict_frame_tx.sv
// Timestamps active monitor verdicts, queues them and
// serialises each as a 4- or 5-byte valid/ready frame.
module verdict_frame_tx
    import verdict_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_W-1:0]             output_b,
    input  logic                          output_b_aktv,
    input  logic [DATA_W-1:0]             output_c,
    input  logic                          output_c_aktv,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic [TS_W-1:0]    ts_q, ts_d;
    logic               ovf_q, ovf_d;
    tx_state_t          state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    verdict_entry_t     wr_e, head;
    logic [ENTRY_W-1:0] head_raw;
    logic               cap, push, pop, hs;
    logic               full, empty;

    assign cap  = en & (output_b_aktv | output_c_aktv);
    assign hs   = tx_valid_q & tx_ready;
    assign push = cap & (~full | pop);
    assign head = verdict_entry_t'(head_raw);
    assign wr_e = '{ts: ts_q,
                    b_aktv: output_b_aktv,
                    c_aktv: output_c_aktv,
                    b: VAL_W'(output_b),
                    c: VAL_W'(output_c)};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_e),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Timestamp advance and sticky drop flag.
    always_comb begin
        ts_d  = en ? ts_q + TS_W'(1) : ts_q;
        ovf_d = ovf_q | (cap & full & ~pop);
    end

    // Frame sequencing; head is popped with the last byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!empty) state_d = ST_HDR;
            ST_HDR:   if (hs) state_d = ST_TS_HI;
            ST_TS_HI: if (hs) state_d = ST_TS_LO;
            ST_TS_LO: if (hs) state_d = head.b_aktv ? ST_VAL_B :
                                        head.c_aktv ? ST_VAL_C : ST_IDLE;
            ST_VAL_B: if (hs) state_d = head.c_aktv ? ST_VAL_C : ST_IDLE;
            ST_VAL_C: if (hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        pop = hs & (state_d == ST_IDLE);
    end

    // Byte for the upcoming state, registered so it is stable under stall.
    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_HDR:   tx_data_d = hdr_byte(head);
            ST_TS_HI: tx_data_d = head.ts[15:8];
            ST_TS_LO: tx_data_d = head.ts[7:0];
            ST_VAL_B: tx_data_d = head.b;
            ST_VAL_C: tx_data_d = head.c;
            default:  tx_data_d = 8'h00;
        endcase
    end

    // State, timestamp and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            ovf_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            ovf_q      <= ovf_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_verdict_frame_tx.sv
// Bench for verdict_frame_tx: event-queue model plus
// directed scenarios and a randomized soak.
module tb_verdict_frame_tx;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, en, tx_ready;
    logic [7:0] output_b, output_c;
    logic       output_b_aktv, output_c_aktv;
    logic [7:0] tx_data;
    logic       tx_valid, overflow;
    logic [3:0] fifo_level;

    int tests = 0;
    int fails = 0;

    verdict_frame_tx #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .output_b      (output_b),
        .output_b_aktv (output_b_aktv),
        .output_c      (output_c),
        .output_c_aktv (output_c_aktv),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: flattened byte stream of queued frames, their lengths,
    // the expected valid flag, drop flag and timestamp.
    logic [7:0] mbytes[$];
    int         mlen[$];
    int         msent;
    bit         mvalid, movf, mok, mzero;
    logic [15:0] mts;
    logic [7:0] obs[$];

    // Compare outputs with the model, then step the model
    // using the inputs the next rising edge will sample.
    always @(negedge clk) begin
        int  lvl0;
        bit  popd;
        if (mok) begin
            chk("tx_valid", tx_valid, mvalid);
            if (mvalid)     chk("tx_data", tx_data, mbytes[0]);
            else if (mzero) chk("tx_data_rst", tx_data, 8'h00);
            chk("fifo_level", fifo_level, mlen.size());
            chk("overflow", overflow, movf);
        end
        if (!rst && tx_valid && tx_ready) obs.push_back(tx_data);
        if (rst) begin
            mbytes.delete();
            mlen.delete();
            msent = 0; mvalid = 0; movf = 0; mts = 0;
            mok = 1; mzero = 1;
        end else if (mok) begin
            mzero = 0;
            lvl0  = mlen.size();
            popd  = 0;
            if (mvalid && tx_ready) begin
                void'(mbytes.pop_front());
                msent++;
                if (msent == mlen[0]) begin
                    popd = 1;
                    void'(mlen.pop_front());
                    msent = 0;
                end
            end
            if (en && (output_b_aktv || output_c_aktv)) begin
                if (lvl0 < DEPTH || popd) begin
                    mbytes.push_back({4'hA, 2'b00, output_c_aktv, output_b_aktv});
                    mbytes.push_back(mts[15:8]);
                    mbytes.push_back(mts[7:0]);
                    if (output_b_aktv) mbytes.push_back(output_b);
                    if (output_c_aktv) mbytes.push_back(output_c);
                    mlen.push_back(3 + int'(output_b_aktv) + int'(output_c_aktv));
                end else begin
                    movf = 1;
                end
            end
            if (en) mts = mts + 16'd1;
            if (popd) mvalid = 0;
            else if (!mvalid && lvl0 > 0) mvalid = 1;
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1; en = 0;
        output_b_aktv = 0; output_c_aktv = 0;
        cyc();
        rst = 0;
    endtask

    task automatic ev(bit ba, bit ca, logic [7:0] b, logic [7:0] c);
        output_b_aktv = ba; output_c_aktv = ca;
        output_b = b; output_c = c;
        cyc();
        output_b_aktv = 0; output_c_aktv = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 500; i++) begin
            if (mlen.size() == 0 && !mvalid) begin
                done = 1;
                break;
            end
            cyc();
        end
        chk("drain_done", done, 1);
    endtask

    function automatic logic [31:0] obs_at(int i);
        return (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] ex[9];
        rst = 1; en = 0; tx_ready = 1;
        output_b = 0; output_c = 0;
        output_b_aktv = 0; output_c_aktv = 0;
        mok = 0; mzero = 0; mvalid = 0; movf = 0; msent = 0; mts = 0;
        cyc(2);
        rst = 0;
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", tx_valid, 0);

        // Single b event at ts=10, with capture latency.
        en = 1;
        cyc(10);
        obs.delete();
        ev(1, 0, 8'h05, 8'h00);
        chk("lat_idle", tx_valid, 0);
        chk("lat_level", fifo_level, 1);
        cyc();
        chk("lat_valid", tx_valid, 1);
        chk("lat_hdr", tx_data, 8'hA1);
        drain();
        ex = '{8'hA1, 8'h00, 8'h0A, 8'h05, 0, 0, 0, 0, 0};
        chk("t1_len", obs.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_byte", obs_at(i), ex[i]);
        chk("t1_level", fifo_level, 0);

        // Both streams at ts=0x01FF, then a back-to-back b event.
        do_reset();
        en = 1;
        cyc(511);
        obs.delete();
        ev(1, 1, 8'hFD, 8'h07);
        ev(1, 0, 8'h42, 8'h00);
        drain();
        ex = '{8'hA3, 8'h01, 8'hFF, 8'hFD, 8'h07, 8'hA1, 8'h02, 8'h00, 8'h42};
        chk("t2_len", obs.size(), 9);
        for (int i = 0; i < 9; i++) chk("t2_byte", obs_at(i), ex[i]);

        // Backpressure held at TS_LO.
        do_reset();
        en = 1;
        cyc(52);
        obs.delete();
        ev(0, 1, 8'h00, 8'h22);
        cyc(3);
        chk("bp_tslo", tx_data, 8'h34);
        tx_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid", tx_valid, 1);
            chk("bp_data", tx_data, 8'h34);
        end
        tx_ready = 1;
        drain();
        ex = '{8'hA2, 8'h00, 8'h34, 8'h22, 0, 0, 0, 0, 0};
        chk("t3_len", obs.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_byte", obs_at(i), ex[i]);

        // Overflow: nine events into eight slots.
        do_reset();
        en = 1;
        tx_ready = 0;
        obs.delete();
        for (int k = 0; k < 9; k++) ev(1, 0, 8'(k + 1), 8'h00);
        cyc();
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        tx_ready = 1;
        drain();
        chk("ovf_len", obs.size(), 32);
        for (int k = 0; k < 8; k++) begin
            chk("ovf_hdr", obs_at(4 * k), 8'hA1);
            chk("ovf_ts", obs_at(4 * k + 2), k);
            chk("ovf_b", obs_at(4 * k + 3), k + 1);
        end
        chk("ovf_sticky", overflow, 1);

        // Enable low freezes timestamp and blocks capture.
        do_reset();
        en = 1;
        cyc(7);
        en = 0;
        obs.delete();
        output_b_aktv = 1; output_c_aktv = 1;
        cyc(20);
        output_b_aktv = 0; output_c_aktv = 0;
        chk("en_obs", obs.size(), 0);
        chk("en_level", fifo_level, 0);
        en = 1;
        ev(1, 0, 8'h09, 8'h00);
        drain();
        chk("en_ts_hi", obs_at(1), 8'h00);
        chk("en_ts_lo", obs_at(2), 8'h07);

        // Timestamp wrap.
        do_reset();
        en = 1;
        cyc(65535);
        obs.delete();
        ev(1, 0, 8'h01, 8'h00);
        ev(1, 0, 8'h02, 8'h00);
        drain();
        chk("wrap_hi0", obs_at(1), 8'hFF);
        chk("wrap_lo0", obs_at(2), 8'hFF);
        chk("wrap_hi1", obs_at(5), 8'h00);
        chk("wrap_lo1", obs_at(6), 8'h00);

        // Reset during VAL_B.
        do_reset();
        en = 1;
        cyc(2);
        ev(1, 1, 8'h10, 8'h20);
        cyc(4);
        chk("mr_valb", tx_data, 8'h10);
        rst = 1;
        cyc();
        rst = 0;
        chk("mr_valid", tx_valid, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_data", tx_data, 8'h00);
        obs.delete();
        cyc(3);
        ev(0, 1, 8'h00, 8'h55);
        drain();
        ex = '{8'hA2, 8'h00, 8'h03, 8'h55, 0, 0, 0, 0, 0};
        chk("t6_len", obs.size(), 4);
        for (int i = 0; i < 4; i++) chk("t6_byte", obs_at(i), ex[i]);

        // Randomized soak against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en            = ($urandom_range(0, 7) != 0);
            output_b_aktv = ($urandom_range(0, 2) == 0);
            output_c_aktv = ($urandom_range(0, 2) == 0);
            output_b      = 8'($urandom);
            output_c      = 8'($urandom);
            tx_ready      = (i % 500 < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
            cyc();
        end
        output_b_aktv = 0; output_c_aktv = 0;
        tx_ready = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
